// File: rtl/cpu_6502_rmw_seq.sv
`default_nettype none
// ============================================================================
// Module   : cpu_6502_rmw_seq
// Purpose  : Multi-cycle sequencer for 6502 read-modify-write memory ops
//            (ASL, LSR, ROL, ROR, INC, DEC). It reads the operand, runs it
//            through the shared ALU, emits the cycle-accurate dummy write of
//            the original value and then writes the result back. N/Z (and C
//            for shifts/rotates) are reported to the status register.
// Ports    : i_clk/i_rst          clock, synchronous active-high reset
//            i_start/i_op/i_addr/i_c   request from decode (sampled in IDLE)
//            o_busy               sequencer occupied
//            o_addr/o_rw/o_wdata/i_rdata/i_rdy   CPU bus
//            o_alu_func/o_alu_left/o_alu_c       shared ALU request
//            i_alu_q/i_alu_c/i_alu_z/i_alu_n     shared ALU response
//            o_flag_we/o_c_we/o_n/o_z/o_c        status register update
//            o_done/o_err         completion / illegal-op pulses
// Revision : 1.0 - initial release
// ============================================================================
module cpu_6502_rmw_seq #(
  parameter int ADDR_W   = 16,
  parameter bit DUMMY_WR = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [2:0]        i_op,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_c,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_rw,
  output logic [7:0]        o_wdata,
  input  logic [7:0]        i_rdata,
  input  logic              i_rdy,
  output logic [3:0]        o_alu_func,
  output logic [7:0]        o_alu_left,
  output logic              o_alu_c,
  input  logic [7:0]        i_alu_q,
  input  logic              i_alu_c,
  input  logic              i_alu_z,
  input  logic              i_alu_n,
  output logic              o_flag_we,
  output logic              o_c_we,
  output logic              o_n,
  output logic              o_z,
  output logic              o_c,
  output logic              o_done,
  output logic              o_err
);

  localparam logic [3:0] C_ALU_NOP = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_DW   = 2'd2,
    S_FW   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_accept;
  logic                w_illegal;

  logic [2:0]          r_op;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_cin;
  logic [7:0]          r_data;
  logic [7:0]          r_res;
  logic                r_res_c;
  logic                r_res_z;
  logic                r_res_n;
  logic                r_err;

  // ALU function code for each legal RMW op.
  function automatic logic [3:0] func_of(input logic [2:0] op);
    case (op)
      3'd0:    func_of = 4'h8;  // ASL
      3'd1:    func_of = 4'h9;  // LSR
      3'd2:    func_of = 4'hA;  // ROL
      3'd3:    func_of = 4'hB;  // ROR
      3'd4:    func_of = 4'h5;  // INC
      3'd5:    func_of = 4'h7;  // DEC
      default: func_of = C_ALU_NOP;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // State register and datapath latches
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_op    <= 3'd0;
      r_addr  <= '0;
      r_cin   <= 1'b0;
      r_data  <= 8'h00;
      r_res   <= 8'h00;
      r_res_c <= 1'b0;
      r_res_z <= 1'b0;
      r_res_n <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_illegal;
      if (w_accept) begin
        r_op   <= i_op;
        r_addr <= i_addr;
        r_cin  <= i_c;
      end
      if (r_state == S_RD && i_rdy) begin
        r_data <= i_rdata;
      end
      // The ALU is driven only during DW; capture its answer for FW.
      if (r_state == S_DW) begin
        r_res   <= i_alu_q;
        r_res_c <= i_alu_c;
        r_res_z <= i_alu_z;
        r_res_n <= i_alu_n;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next state and output decode. Outputs depend on registered state and
  // latches only, so i_start never reaches an output combinationally.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_illegal  = 1'b0;

    o_busy     = (r_state != S_IDLE);
    o_addr     = r_addr;
    o_rw       = 1'b1;
    o_wdata    = 8'h00;
    o_alu_func = C_ALU_NOP;
    o_alu_left = 8'h00;
    o_alu_c    = 1'b0;
    o_flag_we  = 1'b0;
    o_c_we     = 1'b0;
    o_n        = r_res_n;
    o_z        = r_res_z;
    o_c        = r_res_c;
    o_done     = 1'b0;
    o_err      = r_err;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_op <= 3'd5) begin
            w_accept = 1'b1;
            w_next   = S_RD;
          end else begin
            w_illegal = 1'b1;
          end
        end
      end
      S_RD: begin
        if (i_rdy) begin
          w_next = S_DW;
        end
      end
      S_DW: begin
        // The write of the unmodified value is what real 6502 silicon does;
        // some memory-mapped peripherals depend on seeing it.
        if (DUMMY_WR) begin
          o_rw    = 1'b0;
          o_wdata = r_data;
        end
        o_alu_func = func_of(r_op);
        o_alu_left = r_data;
        o_alu_c    = r_cin;
        w_next     = S_FW;
      end
      S_FW: begin
        o_rw      = 1'b0;
        o_wdata   = r_res;
        o_flag_we = 1'b1;
        // Only shifts/rotates (ops 0-3) touch the carry flag.
        o_c_we    = (r_op <= 3'd3);
        o_done    = 1'b1;
        w_next    = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_6502_rmw_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_6502_rmw_seq
// Purpose  : Self-checking bench for cpu_6502_rmw_seq. Two instances (dummy
//            write enabled and disabled) share stimulus; each has its own
//            behavioural ALU. A transaction-level model predicts every output
//            and is compared on each negative clock edge; directed operations
//            pin literal results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_6502_rmw_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [15:0] addr;
  logic        cin;
  logic [7:0]  rdata;
  logic        rdy;

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  bit chk_en = 1'b0;

  // ---------------- outputs of instance A (DUMMY_WR=1) ----------------------
  logic        busy_a, rw_a, aluc_a, fwe_a, cwe_a, n_a, z_a, c_a, done_a, err_a;
  logic [15:0] addr_a;
  logic [7:0]  wdata_a, left_a, aq_a;
  logic [3:0]  func_a;
  logic        acout_a, az_a, an_a;
  // ---------------- outputs of instance B (DUMMY_WR=0) ----------------------
  logic        busy_b, rw_b, aluc_b, fwe_b, cwe_b, n_b, z_b, c_b, done_b, err_b;
  logic [15:0] addr_b;
  logic [7:0]  wdata_b, left_b, aq_b;
  logic [3:0]  func_b;
  logic        acout_b, az_b, an_b;

  // Behavioural shared ALU: {carry, q} for a given function code.
  function automatic logic [8:0] bench_alu(input logic [3:0] f, input logic [7:0] l,
                                           input logic ci);
    case (f)
      4'h8:    bench_alu = {l[7], l[6:0], 1'b0};
      4'h9:    bench_alu = {l[0], 1'b0, l[7:1]};
      4'hA:    bench_alu = {l[7], l[6:0], ci};
      4'hB:    bench_alu = {l[0], ci, l[7:1]};
      4'h5:    bench_alu = {1'b0, l + 8'd1};
      4'h7:    bench_alu = {1'b0, l - 8'd1};
      default: bench_alu = 9'h000;
    endcase
  endfunction

  assign {acout_a, aq_a} = bench_alu(func_a, left_a, aluc_a);
  assign az_a = (aq_a == 8'h00);
  assign an_a = aq_a[7];
  assign {acout_b, aq_b} = bench_alu(func_b, left_b, aluc_b);
  assign az_b = (aq_b == 8'h00);
  assign an_b = aq_b[7];

  cpu_6502_rmw_seq #(.ADDR_W(16), .DUMMY_WR(1'b1)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op), .i_addr(addr), .i_c(cin),
    .o_busy(busy_a), .o_addr(addr_a), .o_rw(rw_a), .o_wdata(wdata_a),
    .i_rdata(rdata), .i_rdy(rdy),
    .o_alu_func(func_a), .o_alu_left(left_a), .o_alu_c(aluc_a),
    .i_alu_q(aq_a), .i_alu_c(acout_a), .i_alu_z(az_a), .i_alu_n(an_a),
    .o_flag_we(fwe_a), .o_c_we(cwe_a), .o_n(n_a), .o_z(z_a), .o_c(c_a),
    .o_done(done_a), .o_err(err_a)
  );

  cpu_6502_rmw_seq #(.ADDR_W(16), .DUMMY_WR(1'b0)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op), .i_addr(addr), .i_c(cin),
    .o_busy(busy_b), .o_addr(addr_b), .o_rw(rw_b), .o_wdata(wdata_b),
    .i_rdata(rdata), .i_rdy(rdy),
    .o_alu_func(func_b), .o_alu_left(left_b), .o_alu_c(aluc_b),
    .i_alu_q(aq_b), .i_alu_c(acout_b), .i_alu_z(az_b), .i_alu_n(an_b),
    .o_flag_we(fwe_b), .o_c_we(cwe_b), .o_n(n_b), .o_z(z_b), .o_c(c_b),
    .o_done(done_b), .o_err(err_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------------
  // Reference model: which bus phase the current instruction is in
  // (0 none, 1 read, 2 dummy, 3 final write) and the arithmetic result.
  // ------------------------------------------------------------------------
  int          m_ph  = 0;
  logic        m_err = 1'b0;
  logic [2:0]  m_op;
  logic [15:0] m_addr;
  logic        m_cin;
  logic [7:0]  m_data;
  logic [7:0]  m_q;
  logic        m_c;

  function automatic logic [3:0] func_code(input logic [2:0] o);
    case (o)
      3'd0: func_code = 4'h8;
      3'd1: func_code = 4'h9;
      3'd2: func_code = 4'hA;
      3'd3: func_code = 4'hB;
      3'd4: func_code = 4'h5;
      default: func_code = 4'h7;
    endcase
  endfunction

  // Result by plain arithmetic: {carry, value}.
  function automatic logic [8:0] ref_rmw(input logic [2:0] o, input logic [7:0] d,
                                         input logic ci);
    int v;
    int cy;
    v = int'(d);
    cy = 0;
    case (o)
      3'd0: begin cy = (v >= 128) ? 1 : 0; v = (v * 2) % 256; end
      3'd1: begin cy = v % 2; v = v / 2; end
      3'd2: begin cy = (v >= 128) ? 1 : 0; v = (v * 2 + int'(ci)) % 256; end
      3'd3: begin cy = v % 2; v = v / 2 + 128 * int'(ci); end
      3'd4: v = (v + 1) % 256;
      default: v = (v + 255) % 256;
    endcase
    ref_rmw = {cy[0], v[7:0]};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ph  = 0;
      m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      if (m_ph == 0) begin
        if (start && op > 3'd5) m_err = 1'b1;
        else if (start) begin
          m_op = op; m_addr = addr; m_cin = cin; m_ph = 1;
        end
      end else if (m_ph == 1) begin
        if (rdy) begin m_data = rdata; m_ph = 2; end
      end else if (m_ph == 2) begin
        {m_c, m_q} = ref_rmw(m_op, m_data, m_cin);
        m_ph = 3;
      end else begin
        m_ph = 0;
      end
    end
  end

  task automatic cmp_dut(input string t, input bit dw, input logic busy_i,
                         input logic [15:0] addr_i, input logic rw_i,
                         input logic [7:0] wdata_i, input logic [3:0] func_i,
                         input logic [7:0] left_i, input logic aluc_i,
                         input logic fwe_i, input logic cwe_i, input logic n_i,
                         input logic z_i, input logic c_i, input logic done_i,
                         input logic err_i);
    logic exp_cwe;
    exp_cwe = (m_ph == 3) && (m_op < 3'd4);
    chk({t, ".busy"}, busy_i, m_ph != 0);
    chk({t, ".err"}, err_i, m_err);
    chk({t, ".done"}, done_i, m_ph == 3);
    chk({t, ".flag_we"}, fwe_i, m_ph == 3);
    chk({t, ".c_we"}, cwe_i, exp_cwe);
    chk({t, ".alu_func"}, func_i, (m_ph == 2) ? func_code(m_op) : 4'hF);
    chk({t, ".alu_left"}, left_i, (m_ph == 2) ? m_data : 8'h00);
    chk({t, ".alu_c"}, aluc_i, (m_ph == 2) ? m_cin : 1'b0);
    chk({t, ".rw"}, rw_i, (m_ph == 3) ? 1'b0 : (m_ph == 2) ? !dw : 1'b1);
    if (m_ph != 0) chk({t, ".addr"}, addr_i, m_addr);
    if (m_ph == 2 && dw) chk({t, ".dummy_wdata"}, wdata_i, m_data);
    if (m_ph == 3) begin
      chk({t, ".wdata"}, wdata_i, m_q);
      chk({t, ".n"}, n_i, m_q[7]);
      chk({t, ".z"}, z_i, m_q == 8'h00);
      if (exp_cwe) chk({t, ".c"}, c_i, m_c);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_dut("A", 1'b1, busy_a, addr_a, rw_a, wdata_a, func_a, left_a, aluc_a,
              fwe_a, cwe_a, n_a, z_a, c_a, done_a, err_a);
      cmp_dut("B", 1'b0, busy_b, addr_b, rw_b, wdata_b, func_b, left_b, aluc_b,
              fwe_b, cwe_b, n_b, z_b, c_b, done_b, err_b);
    end
  end

  // ------------------------------------------------------------------------
  // Directed operation with literal expectations. Inputs change on negedges.
  // ------------------------------------------------------------------------
  task automatic run_op(input logic [2:0] o, input logic [15:0] a, input logic ci,
                        input logic [7:0] rd, input int stall, input bit extra,
                        input logic [7:0] exp_wd, input logic exp_n, input logic exp_z,
                        input logic exp_c, input logic exp_cwe, input string nm);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    start = 1'b1; op = o; addr = a; cin = ci; rdy = 1'b1; rdata = rd;
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      if (t == 2 + stall) begin
        chk({nm, ".A.dw_rw"}, rw_a, 1'b0);
        chk({nm, ".A.dw_wdata"}, wdata_a, rd);
        chk({nm, ".B.dw_rw"}, rw_b, 1'b1);
      end
      if (done_a) begin
        seen = 1'b1;
        chk({nm, ".latency"}, t, 3 + stall);
        chk({nm, ".A.wdata"}, wdata_a, exp_wd);
        chk({nm, ".B.wdata"}, wdata_b, exp_wd);
        chk({nm, ".A.n"}, n_a, exp_n);
        chk({nm, ".A.z"}, z_a, exp_z);
        chk({nm, ".A.c_we"}, cwe_a, exp_cwe);
        chk({nm, ".A.flag_we"}, fwe_a, 1'b1);
        chk({nm, ".B.done"}, done_b, 1'b1);
        if (exp_cwe) chk({nm, ".A.c"}, c_a, exp_c);
        start = 1'b0;
        break;
      end
      // A second request while busy must be ignored entirely.
      start = (extra && t == 1);
      if (extra && t == 1) begin op = 3'd5; addr = 16'h1234; cin = !ci; end
      rdy   = (t > stall);
      rdata = (t > stall) ? rd : 8'($urandom);
    end
    if (!seen) begin
      checks++; fails++;
      $display("FAIL %s.timeout actual=no_done required=done", nm);
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'd0; addr = 16'h0000; cin = 1'b0;
    rdata = 8'h00; rdy = 1'b1;
    repeat (2) @(negedge clk);
    // Reset state of both instances.
    chk("rst.A.busy", busy_a, 1'b0);   chk("rst.A.rw", rw_a, 1'b1);
    chk("rst.A.addr", addr_a, 16'h0);  chk("rst.A.wdata", wdata_a, 8'h00);
    chk("rst.A.func", func_a, 4'hF);   chk("rst.A.left", left_a, 8'h00);
    chk("rst.A.alu_c", aluc_a, 1'b0);  chk("rst.A.pulses", {fwe_a, cwe_a, done_a, err_a}, 4'h0);
    chk("rst.A.nzc", {n_a, z_a, c_a}, 3'b000);
    chk("rst.B.busy", busy_b, 1'b0);   chk("rst.B.rw", rw_b, 1'b1);
    chk("rst.B.func", func_b, 4'hF);   chk("rst.B.pulses", {fwe_b, cwe_b, done_b, err_b}, 4'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    run_op(3'd0, 16'h0200, 1'b0, 8'h81, 0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1, "asl");
    run_op(3'd4, 16'h00FF, 1'b1, 8'hFF, 0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, "inc");
    run_op(3'd5, 16'h0010, 1'b0, 8'h00, 0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, "dec");
    run_op(3'd3, 16'h4000, 1'b1, 8'h01, 3, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1, "ror");
    run_op(3'd1, 16'h0300, 1'b0, 8'h02, 0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, "lsr");
    run_op(3'd2, 16'hBEEF, 1'b1, 8'h40, 1, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0, 1'b1, "rol2nd");

    // Illegal op: error pulse next cycle, no bus activity.
    @(negedge clk);
    start = 1'b1; op = 3'd6; addr = 16'h5555;
    @(negedge clk);
    start = 1'b0;
    chk("ill.A.err", err_a, 1'b1);
    chk("ill.A.busy", busy_a, 1'b0);
    chk("ill.A.rw", rw_a, 1'b1);
    @(negedge clk);
    chk("ill.A.err_end", err_a, 1'b0);

    // Reset during the dummy-write cycle aborts the instruction.
    start = 1'b1; op = 3'd0; addr = 16'h0777; cin = 1'b0; rdata = 8'h55; rdy = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("rstdw.A.in_dw", rw_a, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstdw.A.busy", busy_a, 1'b0);
    chk("rstdw.A.rw", rw_a, 1'b1);
    chk("rstdw.A.func", func_a, 4'hF);
    chk("rstdw.A.pulses", {done_a, fwe_a, cwe_a, err_a}, 4'h0);
    run_op(3'd4, 16'h0001, 1'b0, 8'h7F, 0, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0, "inc_after");

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      op    = 3'($urandom);
      addr  = 16'($urandom);
      cin   = 1'($urandom);
      rdata = 8'($urandom);
      rdy   = ($urandom_range(0, 3) != 0);
      rst   = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_6502_rmw_seq.md
Name: cpu_6502_rmw_seq

Overview:
- Multi-cycle sequencer for 6502 read-modify-write memory instructions: ASL, LSR, ROL, ROR, INC and DEC on a memory operand.
- Sits between the decode/microcode unit and the CPU bus.
  - Issues the operand read.
  - Drives the shared 8-bit ALU with the operand.
  - Emits the 6502-accurate dummy write of the original value, then writes the result.
  - Reports N/Z/C flag updates to the status register.

Parameters:
- ADDR_W, 16, bus address width.
- DUMMY_WR, 1, 1 = DW cycle writes the original value to the bus; 0 = DW cycle is an internal read-idle cycle.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous active-high reset
- i_start  input  1  start request; sampled only in IDLE
- i_op  input  3  0 ASL, 1 LSR, 2 ROL, 3 ROR, 4 INC, 5 DEC, 6-7 illegal
- i_addr  input  ADDR_W  effective operand address
- i_c  input  1  current carry flag, latched at start
- o_busy  output  1  high in any state other than IDLE
- o_addr  output  ADDR_W  bus address
- o_rw  output  1  1 = read, 0 = write
- o_wdata  output  8  bus write data
- i_rdata  input  8  bus read data
- i_rdy  input  1  bus ready; stalls read cycles only
- o_alu_func  output  4  ALU function code
- o_alu_left  output  8  ALU left operand
- o_alu_c  output  1  ALU carry-in
- i_alu_q  input  8  ALU result
- i_alu_c  input  1  ALU carry-out
- i_alu_z  input  1  ALU zero flag
- i_alu_n  input  1  ALU negative flag
- o_flag_we  output  1  one-cycle pulse: write N and Z
- o_c_we  output  1  one-cycle pulse: write C (shift/rotate ops only)
- o_n  output  1  N value to the status register
- o_z  output  1  Z value to the status register
- o_c  output  1  C value to the status register
- o_done  output  1  one-cycle completion pulse
- o_err  output  1  one-cycle pulse: illegal op rejected

Behaviour:
- Reset values: state IDLE, o_busy=0, o_rw=1, o_addr=0, o_wdata=0, o_alu_func=4'hF (NOP), o_alu_left=0, o_alu_c=0, all pulses 0, o_n/o_z/o_c=0, internal regs 0.
- Clocking: all outputs are registered or decoded from registered state only; no combinational path from i_start to outputs.
- States: IDLE -> RD -> DW -> FW -> IDLE.
- IDLE:
  - i_start with i_op<=5: latch op, addr, i_c; go to RD.
  - i_start with i_op 6/7: pulse o_err next cycle; stay in IDLE; no bus activity.
- RD:
  - o_addr=addr, o_rw=1.
  - i_rdy=1: latch i_rdata into the data register; go to DW.
  - i_rdy=0: hold RD; outputs stable.
- DW:
  - o_addr=addr.
  - DUMMY_WR=1: o_rw=0, o_wdata=data.
  - DUMMY_WR=0: o_rw=1.
  - ALU driven this cycle: o_alu_left=data, o_alu_c=latched carry, o_alu_func per op (ASL 8, LSR 9, ROL A, ROR B, INC 5, DEC 7).
  - Latch i_alu_q, i_alu_c, i_alu_z, i_alu_n.
  - i_rdy ignored. Go to FW.
- FW:
  - o_rw=0, o_addr=addr, o_wdata=latched result.
  - o_flag_we=1, o_n/o_z from the latch.
  - o_c_we=1 with o_c=latched carry for ops 0-3 only.
  - o_done=1. Next state IDLE.
- Outside DW: o_alu_func=4'hF; o_alu_left and o_alu_c hold 0.
- Latency: start in cycle T with i_rdy=1 gives RD at T+1, DW at T+2, FW/done at T+3. Each cycle i_rdy=0 in RD adds one cycle.
- Back-to-back: i_start asserted in the same cycle as o_done is ignored (state is FW). Earliest accepted start is the cycle after o_done.
- i_start while busy: ignored, including its op, addr and carry.
- Wrap-around arithmetic: INC FF -> 00 (Z=1); DEC 00 -> FF (N=1). No carry write for INC/DEC.
- Reset asserted in any state: next cycle IDLE with reset values.
  - No o_done, o_flag_we or o_err.
  - An aborted write cycle is not completed.

Test Plan:
- ASL at addr 0x0200, rdata=0x81, i_c=0, rdy=1 -> RD T+1, dummy write 0x81 at T+2, write 0x02 at T+3; N=0 Z=0 C=1; o_c_we=1; o_done at T+3.
- INC at 0x00FF, rdata=0xFF, i_c=1 -> final write 0x00, Z=1 N=0, o_flag_we=1, o_c_we=0; DEC with rdata=0x00 -> 0xFF, N=1.
- ROR rdata=0x01, i_c=1, rdy held low 3 cycles in RD -> o_addr/o_rw stable while stalled; write 0x80; C=1 N=1; o_done at T+6.
- i_op=6 with i_start -> o_err pulse, o_busy stays 0, o_rw stays 1; second i_start during RD of a legal op -> ignored, original op completes.
- DUMMY_WR=0 build, LSR rdata=0x02 -> DW cycle o_rw=1; write 0x01 only in FW; C=0 Z=0.
- i_rst asserted during DW -> next cycle IDLE, o_rw=1, o_alu_func=F; no o_done or flag pulses; new op afterwards completes normally.
